// File: rtl/rpn_controlador_if.sv
// Handshake bundle between the RPN keypad controller and its surroundings.
//   confirma, cancela     raw push buttons (asynchronous, active-high)
//   op_in, overflow_in    operation switches and ALU overflow flag
//   habilitaA, habilitaB  one-cycle operand-stack push strobes
//   op_sel, sel_dado      latched ALU operation and stack data-mux select
//   estado                current state code for display
//   resultado_valido      ALU result valid for display
//   erro                  sticky error indicator
// The master modport drives the buttons and switches; the slave modport is the controller.
interface rpn_controlador_if;
  logic       confirma;
  logic       cancela;
  logic [2:0] op_in;
  logic       overflow_in;
  logic       habilitaA;
  logic       habilitaB;
  logic [2:0] op_sel;
  logic       sel_dado;
  logic [1:0] estado;
  logic       resultado_valido;
  logic       erro;

  modport master (
    output confirma, cancela, op_in, overflow_in,
    input  habilitaA, habilitaB, op_sel, sel_dado, estado, resultado_valido, erro
  );

  modport slave (
    input  confirma, cancela, op_in, overflow_in,
    output habilitaA, habilitaB, op_sel, sel_dado, estado, resultado_valido, erro
  );
endinterface

// File: rtl/rpn_controlador.sv
// RPN calculator keypad controller: walks the user through loading operand A, operand B,
// choosing the operation and showing the result, with a "back" button stepping one state back.
//   clk  system clock, all state changes on its rising edge
//   rst  asynchronous active-low reset
//   bus  rpn_controlador_if.slave (buttons, switches, strobes, status)
// Parameters: SYNC_STAGES (2..4) synchronizer depth per button; OP_INVALIDA reserved op code.
// Optional build macro RPN_ENCADEIA_EN: confirming in RESULTADO pushes the ALU result as the
// next first operand and continues in CARGA_B instead of restarting in CARGA_A.
module rpn_controlador #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [2:0]  OP_INVALIDA = 3'b111
) (
  input logic               clk,
  input logic               rst,
  rpn_controlador_if.slave  bus
);

  typedef enum logic [1:0] {
    StCargaA    = 2'b00,
    StCargaB    = 2'b01,
    StSelOp     = 2'b10,
    StResultado = 2'b11
  } estadoT;

  // Button conditioning: synchronizer chain, previous-level flop and a registered pulse.
  // Input rise to pulse is SYNC_STAGES+1 edges; the resulting strobe shows one edge later.
  logic [SYNC_STAGES-1:0] confSyncQ, cancSyncQ;
  logic                   confLastQ, cancLastQ;
  logic                   pConfQ, pCancQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      confSyncQ <= '0;
      cancSyncQ <= '0;
      confLastQ <= 1'b0;
      cancLastQ <= 1'b0;
      pConfQ    <= 1'b0;
      pCancQ    <= 1'b0;
    end else begin
      confSyncQ <= {confSyncQ[SYNC_STAGES-2:0], bus.confirma};
      cancSyncQ <= {cancSyncQ[SYNC_STAGES-2:0], bus.cancela};
      confLastQ <= confSyncQ[SYNC_STAGES-1];
      cancLastQ <= cancSyncQ[SYNC_STAGES-1];
      pConfQ    <= confSyncQ[SYNC_STAGES-1] & ~confLastQ;
      pCancQ    <= cancSyncQ[SYNC_STAGES-1] & ~cancLastQ;
    end
  end

  estadoT     estadoQ, estadoD;
  logic       habAQ, habAD;
  logic       habBQ, habBD;
  logic [2:0] opSelQ, opSelD;
  logic       selDadoQ, selDadoD;
  logic       resValQ, resValD;
  logic       erroQ, erroD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estadoQ  <= StCargaA;
      habAQ    <= 1'b0;
      habBQ    <= 1'b0;
      opSelQ   <= 3'b000;
      selDadoQ <= 1'b0;
      resValQ  <= 1'b0;
      erroQ    <= 1'b0;
    end else begin
      estadoQ  <= estadoD;
      habAQ    <= habAD;
      habBQ    <= habBD;
      opSelQ   <= opSelD;
      selDadoQ <= selDadoD;
      resValQ  <= resValD;
      erroQ    <= erroD;
    end
  end

  always_comb begin
    estadoD  = estadoQ;
    habAD    = 1'b0;
    habBD    = 1'b0;
    opSelD   = opSelQ;
    selDadoD = 1'b0;
    resValD  = resValQ;
    erroD    = erroQ;
    if (pCancQ) begin
      // Back wins over a simultaneous confirm; never strobes.
      erroD = 1'b0;
      case (estadoQ)
        StCargaB:    estadoD = StCargaA;
        StSelOp:     estadoD = StCargaB;
        StResultado: begin
          estadoD = StSelOp;
          resValD = 1'b0;
        end
        default:     ;
      endcase
    end else begin
      case (estadoQ)
        StCargaA: begin
          if (pConfQ) begin
            habAD   = 1'b1;
            estadoD = StCargaB;
          end
        end
        StCargaB: begin
          if (pConfQ) begin
            habBD   = 1'b1;
            estadoD = StSelOp;
          end
        end
        StSelOp: begin
          if (pConfQ) begin
            if (bus.op_in == OP_INVALIDA) begin
              erroD = 1'b1;
            end else begin
              opSelD  = bus.op_in;
              erroD   = 1'b0;
              resValD = 1'b1;
              estadoD = StResultado;
            end
          end
        end
        StResultado: begin
          // Error mirrors the ALU overflow for as long as the result is shown.
          erroD = bus.overflow_in;
          if (pConfQ) begin
            resValD = 1'b0;
            erroD   = 1'b0;
`ifdef RPN_ENCADEIA_EN
            habAD    = 1'b1;
            selDadoD = 1'b1;
            estadoD  = StCargaB;
`else
            estadoD  = StCargaA;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.habilitaA        = habAQ;
  assign bus.habilitaB        = habBQ;
  assign bus.op_sel           = opSelQ;
  assign bus.sel_dado         = selDadoQ;
  assign bus.estado           = estadoQ;
  assign bus.resultado_valido = resValQ;
  assign bus.erro             = erroQ;

endmodule
